// File: rtl/bp_me_pkg.sv
// Shared types and helpers for the inbound arbitration buffer and its channel FIFOs.
package bp_me_pkg;

    typedef enum logic [1:0] {
        e_arb_idle   = 2'd0,
        e_arb_grant  = 2'd1,
        e_arb_locked = 2'd2
    } bp_arb_state_e;

    // Never returns 0 so single-entry quantities still get a 1-bit field.
    function automatic int safe_clog2(input int x);
        return (x <= 1) ? 1 : $clog2(x);
    endfunction

endpackage

// File: rtl/bp_cce_inbound_arb_buffer_if.sv
// Bundle of the inbound channel handshakes and the single arbitrated output.
interface bp_cce_inbound_arb_buffer_if #(
    parameter int num_ch_p = 2,
    parameter int width_p  = 64,
    parameter int els_p    = 4
) ();
    import bp_me_pkg::*;

    localparam int lg_ch_lp     = safe_clog2(num_ch_p);
    localparam int cnt_width_lp = safe_clog2(els_p + 1);

    logic [num_ch_p*width_p-1:0]      data_i;
    logic [num_ch_p-1:0]              v_i;
    logic [num_ch_p-1:0]              ready_o;
    logic [width_p-1:0]               data_o;
    logic [lg_ch_lp-1:0]              ch_id_o;
    logic                             v_o;
    logic                             yumi_i;
    logic                             lock_i;
    logic [num_ch_p*cnt_width_lp-1:0] count_o;
    logic                             error_o;

    modport slave (
        input  data_i, v_i, yumi_i, lock_i,
        output ready_o, data_o, ch_id_o, v_o, count_o, error_o
    );

    modport master (
        output data_i, v_i, yumi_i, lock_i,
        input  ready_o, data_o, ch_id_o, v_o, count_o, error_o
    );
endinterface

// File: rtl/bp_me_chan_fifo.sv
// Per-channel circular FIFO; a full FIFO refuses enqueue even when popped the same cycle.
module bp_me_chan_fifo
    import bp_me_pkg::*;
#(
    parameter int width_p = 64,
    parameter int els_p   = 4
) (
    input  logic                                  clk_i,
    input  logic                                  reset_n_i,
    input  logic [width_p-1:0]                    data_i,
    input  logic                                  v_i,
    output logic                                  ready_o,
    output logic [width_p-1:0]                    data_o,
    output logic                                  v_o,
    input  logic                                  yumi_i,
    output logic [safe_clog2(els_p+1)-1:0]        count_o
);
    localparam int cnt_width_lp = safe_clog2(els_p + 1);
    localparam int ptr_width_lp = safe_clog2(els_p);

    logic [els_p-1:0][width_p-1:0] mem_q;
    logic [ptr_width_lp-1:0]       wr_ptr_q, wr_ptr_d;
    logic [ptr_width_lp-1:0]       rd_ptr_q, rd_ptr_d;
    logic [cnt_width_lp-1:0]       count_q, count_d;
    logic                          enq, deq;

    // Ready is gated by reset so nothing is offered while the buffer is being cleared.
    assign ready_o = reset_n_i & (count_q != cnt_width_lp'(els_p));
    assign v_o     = (count_q != '0);
    assign enq     = v_i & ready_o;
    assign deq     = yumi_i & v_o;
    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (enq) begin
            wr_ptr_d = (wr_ptr_q == ptr_width_lp'(els_p - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (deq) begin
            rd_ptr_d = (rd_ptr_q == ptr_width_lp'(els_p - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        count_d = count_q + cnt_width_lp'(enq) - cnt_width_lp'(deq);
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (enq) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/bp_cce_inbound_arb_buffer.sv
// Buffers num_ch_p inbound message channels and round-robin arbitrates them onto one
// valid->yumi output, with an optional lock that pins the grant to one channel.
//
//   state         | meaning
//   e_arb_idle    | no grant held; present first non-empty channel at/after rr_ptr
//   e_arb_grant   | grant_q presented and waiting for yumi
//   e_arb_locked  | grant pinned to grant_q; v_o follows that channel only
module bp_cce_inbound_arb_buffer
    import bp_me_pkg::*;
#(
    parameter int num_ch_p = 2,
    parameter int width_p  = 64,
    parameter int els_p    = 4
) (
    input  logic                           clk_i,
    input  logic                           reset_n_i,
    bp_cce_inbound_arb_buffer_if.slave     io
);
    localparam int lg_ch_lp     = safe_clog2(num_ch_p);
    localparam int cnt_width_lp = safe_clog2(els_p + 1);

    bp_arb_state_e                           state_q, state_d;
    logic [lg_ch_lp-1:0]                     grant_q, grant_d;
    logic [lg_ch_lp-1:0]                     rr_ptr_q, rr_ptr_d;
    logic                                    error_q, error_d;

    logic [num_ch_p-1:0]                     ready;
    logic [num_ch_p-1:0]                     nonempty;
    logic [num_ch_p-1:0]                     deq;
    logic [num_ch_p-1:0][width_p-1:0]        head;
    logic [num_ch_p-1:0][cnt_width_lp-1:0]   count;
    logic [lg_ch_lp-1:0]                     pick_ch, sel;
    logic                                    pick_v, out_v;

    for (genvar c = 0; c < num_ch_p; c++) begin : g_ch
        bp_me_chan_fifo #(
            .width_p (width_p),
            .els_p   (els_p)
        ) u_fifo (
            .clk_i     (clk_i),
            .reset_n_i (reset_n_i),
            .data_i    (io.data_i[c*width_p +: width_p]),
            .v_i       (io.v_i[c]),
            .ready_o   (ready[c]),
            .data_o    (head[c]),
            .v_o       (nonempty[c]),
            .yumi_i    (deq[c]),
            .count_o   (count[c])
        );
    end

    // Scan downward so the lowest offset from rr_ptr wins.
    always_comb begin
        pick_v  = 1'b0;
        pick_ch = '0;
        for (int i = num_ch_p - 1; i >= 0; i--) begin
            if (nonempty[(int'(rr_ptr_q) + i) % num_ch_p]) begin
                pick_v  = 1'b1;
                pick_ch = lg_ch_lp'((int'(rr_ptr_q) + i) % num_ch_p);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        error_d  = error_q;
        deq      = '0;
        sel      = (state_q == e_arb_idle) ? pick_ch : grant_q;
        out_v    = (state_q == e_arb_idle) ? pick_v : nonempty[sel];

        if (io.yumi_i) begin
            if (out_v) begin
                deq[sel] = 1'b1;
                grant_d  = sel;
                if (io.lock_i) begin
                    state_d = e_arb_locked;
                end else begin
                    state_d  = e_arb_idle;
                    rr_ptr_d = (int'(sel) == num_ch_p - 1) ? '0 : sel + 1'b1;
                end
            end else begin
                error_d = 1'b1;
            end
        end else if (state_q == e_arb_idle && pick_v) begin
            state_d = e_arb_grant;
            grant_d = pick_ch;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q  <= e_arb_idle;
            grant_q  <= '0;
            rr_ptr_q <= '0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            error_q  <= error_d;
        end
    end

    assign io.ready_o = ready;
    assign io.data_o  = head[sel];
    assign io.ch_id_o = sel;
    assign io.v_o     = out_v;
    assign io.count_o = count;
    assign io.error_o = error_q;

endmodule

// File: tb/tb_bp_cce_inbound_arb_buffer.sv
// Scoreboard bench: a queue-based reference model predicts each cycle's outputs and a
// separate monitor compares them against the buffer.
module tb_bp_cce_inbound_arb_buffer;
    import bp_me_pkg::*;

    localparam int N  = 2;
    localparam int W  = 64;
    localparam int E  = 4;
    localparam int CW = 3;
    localparam int LG = 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    bp_cce_inbound_arb_buffer_if #(.num_ch_p(N), .width_p(W), .els_p(E)) bus ();

    bp_cce_inbound_arb_buffer #(.num_ch_p(N), .width_p(W), .els_p(E)) dut (
        .clk_i     (clk),
        .reset_n_i (rst_n),
        .io        (bus)
    );

    typedef struct packed {
        logic          v;
        logic [LG-1:0] ch;
        logic [W-1:0]  data;
        logic [N-1:0]  ready;
        logic [N*CW-1:0] cnt;
        logic          err;
    } exp_t;

    exp_t expq[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model state: message queues, round-robin pointer, presented/locked grant.
    logic [W-1:0] mq[N][$];
    int rr      = 0;
    int held    = -1;
    bit locked  = 0;
    int lock_g  = 0;
    bit err     = 0;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ym: 0 = no yumi, 1 = yumi only when the model says data is valid, 2 = forced yumi.
    task automatic cycle(input logic [N-1:0] v, input int ym, input bit lk);
        logic [W-1:0] d[N];
        exp_t e;
        int   g;
        bit   vo;
        bit   yumi;
        @(negedge clk);
        for (int c = 0; c < N; c++) begin
            d[c] = {$urandom, $urandom};
            bus.data_i[c*W +: W] = d[c];
        end
        bus.v_i = v;
        bus.lock_i = lk;

        e = '0;
        for (int c = 0; c < N; c++) begin
            e.ready[c] = (mq[c].size() < E);
            e.cnt[c*CW +: CW] = CW'(mq[c].size());
        end
        g  = 0;
        vo = 0;
        if (locked) begin
            g  = lock_g;
            vo = (mq[g].size() > 0);
        end else if (held >= 0) begin
            g  = held;
            vo = 1;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (!vo && mq[(rr + i) % N].size() > 0) begin
                    g  = (rr + i) % N;
                    vo = 1;
                end
            end
        end
        e.v = vo;
        if (vo) begin
            e.ch   = LG'(g);
            e.data = mq[g][0];
        end
        e.err = err;
        expq.push_back(e);

        yumi = (ym == 2) || (ym == 1 && vo);
        bus.yumi_i = yumi;
        if (yumi) begin
            if (vo) begin
                void'(mq[g].pop_front());
                held = -1;
                if (lk) begin
                    locked = 1;
                    lock_g = g;
                end else begin
                    locked = 0;
                    rr = (g + 1) % N;
                end
            end else begin
                err = 1;
            end
        end else if (vo && !locked) begin
            held = g;
        end
        for (int c = 0; c < N; c++) begin
            if (v[c] && e.ready[c]) mq[c].push_back(d[c]);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                chk("v_o", W'(bus.v_o), W'(e.v));
                chk("ready_o", W'(bus.ready_o), W'(e.ready));
                chk("count_o", W'(bus.count_o), W'(e.cnt));
                chk("error_o", W'(bus.error_o), W'(e.err));
                if (e.v) begin
                    chk("ch_id_o", W'(bus.ch_id_o), W'(e.ch));
                    chk("data_o", bus.data_o, e.data);
                end
            end
        end
    end

    initial begin : driver
        logic [N-1:0] vv;
        bus.data_i = '0;
        bus.v_i    = '0;
        bus.yumi_i = 1'b0;
        bus.lock_i = 1'b0;

        #1 rst_n = 1'b0;
        #1;
        chk("reset ready_o", W'(bus.ready_o), '0);
        chk("reset v_o", W'(bus.v_o), '0);
        chk("reset error_o", W'(bus.error_o), '0);
        chk("reset count_o", W'(bus.count_o), '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post-reset ready_o", W'(bus.ready_o), W'({N{1'b1}}));

        // Two messages per channel, yumi whenever valid: grants alternate 0,1,0,1.
        repeat (2) cycle(2'b11, 0, 0);
        repeat (5) cycle(2'b00, 1, 0);

        // Fill channel 0 to depth, then one extra push that must be refused.
        repeat (5) cycle(2'b01, 0, 0);
        cycle(2'b00, 0, 0);
        repeat (5) cycle(2'b00, 1, 0);

        // Lock on channel 0 while channel 1 waits.
        cycle(2'b01, 0, 0);
        cycle(2'b11, 0, 0);
        cycle(2'b10, 0, 0);
        repeat (3) cycle(2'b00, 1, 1);
        cycle(2'b01, 0, 0);
        repeat (4) cycle(2'b00, 1, 0);

        // Yumi with nothing valid: sticky error, no state change.
        cycle(2'b00, 2, 0);
        repeat (2) cycle(2'b00, 0, 0);

        // Streaming through channel 1 exercises pointer wrap.
        repeat (10) cycle(2'b10, 1, 0);
        repeat (2) cycle(2'b00, 1, 0);

        repeat (400) cycle(N'($urandom), ($urandom_range(0, 9) < 6) ? 1 : 0,
                           ($urandom_range(0, 3) == 0));

        // Drain, feeding a locked-but-empty channel so the lock can be released.
        repeat (60) begin
            vv = '0;
            if (locked && mq[lock_g].size() == 0) vv[lock_g] = 1'b1;
            cycle(vv, 1, 0);
        end

        // Three buffered messages, then reset between clock edges.
        cycle(2'b11, 0, 0);
        cycle(2'b01, 0, 0);
        cycle(2'b00, 0, 0);
        @(negedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async reset v_o", W'(bus.v_o), '0);
        chk("async reset count_o", W'(bus.count_o), '0);
        chk("async reset ready_o", W'(bus.ready_o), '0);
        expq.delete();
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bp_cce_inbound_arb_buffer.md
BP_CCE_INBOUND_ARB_BUFFER -- requirements
Module: bp_cce_inbound_arb_buffer

Interface
REQ-001 Parameter num_ch_p, default 2: number of inbound channels; SHALL be >= 1.
REQ-002 Parameter width_p, default 64: message width in bits; SHALL be >= 1.
REQ-003 Parameter els_p, default 4: per-channel buffer depth; SHALL be >= 2.
REQ-004 Localparams: lg_ch_lp = BSG_SAFE_CLOG2(num_ch_p); cnt_width_lp = BSG_SAFE_CLOG2(els_p+1).
REQ-005 Clocking and reset (already decided): one clock; reset is asynchronous and active-low.
REQ-006 clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-007 reset_n_i  input  1  asynchronous, active-low reset.
REQ-008 data_i  input  num_ch_p*width_p  inbound messages; channel c occupies bits [c*width_p +: width_p].
REQ-009 v_i  input  num_ch_p  per-channel valid (ready&valid).
REQ-010 ready_o  output  num_ch_p  per-channel ready; high when the channel buffer is not full.
REQ-011 data_o  output  width_p  head message of the granted channel.
REQ-012 ch_id_o  output  lg_ch_lp  index of the granted channel.
REQ-013 v_o  output  1  high when any channel is non-empty (valid->yumi).
REQ-014 yumi_i  input  1  consumer accepts data_o this cycle.
REQ-015 lock_i  input  1  sampled with yumi_i; holds the grant on the current channel.
REQ-016 count_o  output  num_ch_p*cnt_width_lp  per-channel occupancy.
REQ-017 error_o  output  1  sticky protocol-error flag.

Function
REQ-018 Enqueue on channel c SHALL occur when v_i[c] & ready_o[c]; ready_o[c] SHALL be low when count[c]==els_p.
REQ-019 No bypass: a message enqueued into an empty channel SHALL first appear on data_o the following cycle at the earliest.
REQ-020 A channel that is full at the start of a cycle SHALL NOT accept an enqueue that cycle, even if it is dequeued in the same cycle.
REQ-021 Per-channel storage SHALL be circular; read and write pointers SHALL wrap from els_p-1 to 0.
REQ-022 Simultaneous enqueue and dequeue on a non-full, non-empty channel SHALL leave count unchanged.
REQ-023 Arbiter states: IDLE (no grant), GRANT (channel g presented), LOCKED (grant pinned to g).
REQ-024 In IDLE, the arbiter SHALL pick the first non-empty channel at or after rr_ptr (modulo num_ch_p), go to GRANT, and assert v_o in the same cycle.
REQ-025 While v_o is high and yumi_i is low, ch_id_o and data_o SHALL remain stable.
REQ-026 On yumi_i with lock_i low: dequeue the head of g; set rr_ptr = (g+1) mod num_ch_p; re-arbitrate next cycle.
REQ-027 On yumi_i with lock_i high: dequeue the head of g and enter LOCKED; the next grant SHALL be g even if g is empty (v_o low until g refills).
REQ-028 LOCKED SHALL exit to GRANT/IDLE on the first yumi_i with lock_i low.
REQ-029 yumi_i while v_o is low SHALL set error_o, SHALL NOT dequeue anything, and SHALL NOT change state; error_o clears only on reset.
REQ-030 count_o SHALL reflect post-edge occupancy with 0 latency relative to the registered count.

Reset
REQ-031 While reset_n_i is low: all pointers = 0, counts = 0, rr_ptr = 0, state = IDLE, v_o = 0, error_o = 0, ready_o = 0.
REQ-032 In the first cycle after reset_n_i deasserts, ready_o SHALL be all ones.
REQ-033 Reset asserted mid-transfer SHALL discard all buffered messages immediately, without waiting for a clock edge.

Structure
REQ-034 The arbiter state enum (e_arb_idle, e_arb_grant, e_arb_locked) SHALL be declared in bp_me_pkg.
REQ-035 One sub-module, bp_me_chan_fifo (width_p, els_p, async active-low reset, count output), SHALL be instantiated num_ch_p times.
REQ-036 The arbiter and lock logic SHALL reside in the top module; it SHALL have no combinational path from yumi_i to ready_o.

Verification
REQ-037 Reset, then with num_ch_p=2, els_p=4: push 4 messages on ch0 -> ready_o[0]=0, count0=4; a 5th push is not accepted.
REQ-038 ch0 and ch1 each hold 2 messages, yumi_i held high -> ch_id_o sequence 0,1,0,1.
REQ-039 lock_i=1 on the first yumi of ch0 while ch1 is non-empty -> next grant is ch0; ch1 is served only after a yumi with lock_i=0.
REQ-040 yumi_i pulse while all channels are empty -> error_o=1 and stays 1; counts unchanged.
REQ-041 Wrap: 10 push/pop pairs on ch1 with els_p=4 -> data_o order matches push order; count1 never exceeds 1.
REQ-042 Assert reset_n_i low with 3 messages buffered, between clock edges -> v_o=0 and count_o=0 immediately.
